// File: rtl/lmac_pkg.sv
// lmac_pkg: shared defaults and helpers for the LMAC TX datapath.
//   LMAC_DATA_W_DFLT       default data width in bits
//   LMAC_TXFIFO_DEPTH_DFLT default TX FIFO entry count
//   lmac_ptr_w()           pointer width including the wrap bit
package lmac_pkg;

    localparam int LMAC_DATA_W_DFLT       = 64;
    localparam int LMAC_TXFIFO_DEPTH_DFLT = 16;

    // Address bits plus one wrap bit, so full and empty are distinguishable.
    function automatic int lmac_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lmac_txfifo_ram.sv
// lmac_txfifo_ram: 1-write/1-read synchronous RAM, DEPTH x DATA_W.
//   clk, rst          clock, async active-high reset (read register only)
//   i_we/i_waddr/i_wdata  write port
//   i_re/i_raddr      read port; o_rdata registered, holds when i_re=0
// The storage array itself is never reset.
module lmac_txfifo_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/lmac_tx_fifo.sv
// lmac_tx_fifo: synchronous TX FIFO with registered read and registered flags.
//   clk, rst         clock, async active-high reset
//   flush            synchronous clear; overrides tx_we and rd_en
//   tx_we, tx_data   write request/data (dropped while full)
//   rd_en            read request (ignored while empty)
//   rd_data/rd_valid popped word, valid the cycle after an accepted read
//   full/empty/afull/wused  occupancy after the current edge
//   ovf_cnt          saturating dropped-write count, only when the macro
//                    LMAC_TXFIFO_OVF_CNT_EN is defined
module lmac_tx_fifo
    import lmac_pkg::*;
#(
    parameter int DATA_W   = LMAC_DATA_W_DFLT,
    parameter int DEPTH    = LMAC_TXFIFO_DEPTH_DFLT,
    parameter int AFULL_TH = DEPTH - 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   tx_we,
    input  logic [DATA_W-1:0]      tx_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   afull,
    output logic [$clog2(DEPTH):0] wused
`ifdef LMAC_TXFIFO_OVF_CNT_EN
    ,
    output logic [15:0]            ovf_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = lmac_ptr_w(DEPTH);

    if (DATA_W < 1) begin : g_bad_data_w
        $error("lmac_tx_fifo: DATA_W must be >= 1");
    end
    if (DEPTH < 4 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lmac_tx_fifo: DEPTH must be a power of two in 4..1024");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH - 1) begin : g_bad_afull
        $error("lmac_tx_fifo: AFULL_TH must be in 1..DEPTH-1");
    end

    logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_wused;
    logic          r_full, r_empty, r_afull, r_rd_valid;
    logic          w_wr_acc, w_rd_acc;
    logic [PW-1:0] w_wr_nxt, w_rd_nxt, w_used_nxt;

    // Accept decisions use the registered flags, so a write while full is
    // dropped even if a read frees a slot on the same edge.
    assign w_wr_acc   = tx_we & ~r_full  & ~flush;
    assign w_rd_acc   = rd_en & ~r_empty & ~flush;
    assign w_wr_nxt   = r_wr_ptr + PW'(w_wr_acc);
    assign w_rd_nxt   = r_rd_ptr + PW'(w_rd_acc);
    assign w_used_nxt = r_wused + PW'(w_wr_acc) - PW'(w_rd_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wused    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_afull    <= 1'b0;
            r_rd_valid <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wused    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_afull    <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_wused    <= w_used_nxt;
            // Flags come from next-state pointers so they carry no lag.
            r_full     <= (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]) &&
                          (w_wr_nxt[AW] != w_rd_nxt[AW]);
            r_empty    <= (w_wr_nxt == w_rd_nxt);
            r_afull    <= (w_used_nxt >= PW'(AFULL_TH));
            r_rd_valid <= w_rd_acc;
        end
    end

    lmac_txfifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (tx_data),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (rd_data)
    );

    assign rd_valid = r_rd_valid;
    assign full     = r_full;
    assign empty    = r_empty;
    assign afull    = r_afull;
    assign wused    = r_wused;

`ifdef LMAC_TXFIFO_OVF_CNT_EN
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_cnt <= '0;
        end else if (flush) begin
            r_ovf_cnt <= '0;
        end else if (tx_we && r_full && r_ovf_cnt != 16'hFFFF) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_lmac_tx_fifo.sv
// tb_lmac_tx_fifo: randomized + directed bench for lmac_tx_fifo against a
// queue-based occupancy/data model. Understands LMAC_TXFIFO_OVF_CNT_EN.
module tb_lmac_tx_fifo;

    localparam int DATA_W   = 64;
    localparam int DEPTH    = 16;
    localparam int AFULL_TH = 12;
    localparam int PW       = 5;

    logic              clk = 1'b0;
    logic              rst, flush, tx_we, rd_en;
    logic [DATA_W-1:0] tx_data, rd_data;
    logic              rd_valid, full, empty, afull;
    logic [PW-1:0]     wused;
`ifdef LMAC_TXFIFO_OVF_CNT_EN
    logic [15:0]       ovf_cnt;
`endif

    always #5 clk = ~clk;

    lmac_tx_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .tx_we    (tx_we),
        .tx_data  (tx_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty),
        .afull    (afull),
        .wused    (wused)
`ifdef LMAC_TXFIFO_OVF_CNT_EN
        ,
        .ovf_cnt  (ovf_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: FIFO contents as a queue, last popped word, dropped-write count.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] m_rdd = '0;
    bit                m_rdv = 1'b0;
    int                m_ovf = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rdd = '0;
        m_rdv = 1'b0;
        m_ovf = 0;
    endtask

    // Applied once per rising edge with the inputs that were presented.
    task automatic model_update();
        bit rd_ok, wr_ok;
        if (flush) begin
            mq.delete();
            m_rdv = 1'b0;
            m_ovf = 0;
        end else begin
            rd_ok = rd_en && (mq.size() != 0);
            wr_ok = tx_we && (mq.size() != DEPTH);
            m_rdv = rd_ok;
            if (rd_ok) m_rdd = mq.pop_front();
            if (wr_ok) mq.push_back(tx_data);
            else if (tx_we && m_ovf < 65535) m_ovf++;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wused",    64'(wused),    64'(mq.size()));
            chk("full",     64'(full),     64'(mq.size() == DEPTH));
            chk("empty",    64'(empty),    64'(mq.size() == 0));
            chk("afull",    64'(afull),    64'(mq.size() >= AFULL_TH));
            chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
            chk("rd_data",  rd_data,       m_rdd);
`ifdef LMAC_TXFIFO_OVF_CNT_EN
            chk("ovf_cnt",  64'(ovf_cnt),  64'(m_ovf));
`endif
        end
    end

    task automatic step(input bit we, input logic [DATA_W-1:0] d, input bit re, input bit fl);
        tx_we   = we;
        tx_data = d;
        rd_en   = re;
        flush   = fl;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_wused"},    64'(wused),    64'd0);
        chk({tag, "_empty"},    64'(empty),    64'd1);
        chk({tag, "_full"},     64'(full),     64'd0);
        chk({tag, "_afull"},    64'(afull),    64'd0);
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_rd_data"},  rd_data,       64'd0);
`ifdef LMAC_TXFIFO_OVF_CNT_EN
        chk({tag, "_ovf_cnt"},  64'(ovf_cnt),  64'd0);
`endif
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; tx_we = 1'b0; rd_en = 1'b0; tx_data = '0;
        #1;
        reset_checks("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;

        // Fill to full with 0..15; afull rises at the 12th write.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 64'(i), 1'b0, 1'b0);
            chk("fill_afull", 64'(afull), 64'((i + 1) >= 12));
        end
        chk("fill_full",  64'(full),  64'd1);
        chk("fill_wused", 64'(wused), 64'd16);

        // Drop while full, then drain in order.
        step(1'b1, 64'hAA, 1'b0, 1'b0);
        chk("drop_wused", 64'(wused), 64'd16);
`ifdef LMAC_TXFIFO_OVF_CNT_EN
        chk("drop_ovf", 64'(ovf_cnt), 64'd1);
`endif
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("drain_data",  rd_data,        64'(i));
            chk("drain_valid", 64'(rd_valid),  64'd1);
        end
        chk("drain_empty", 64'(empty), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("underflow_valid", 64'(rd_valid), 64'd0);
        chk("hold_data",       rd_data,       64'hF);

        // Simultaneous write+read on empty: only the write lands.
        step(1'b1, 64'h1234, 1'b1, 1'b0);
        chk("we_re_empty_wused", 64'(wused),    64'd1);
        chk("we_re_empty_valid", 64'(rd_valid), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("we_re_empty_data", rd_data, 64'h1234);

        // Steady-state streaming at occupancy 8 wraps the pointers.
        for (int i = 0; i < 8; i++) step(1'b1, 64'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 64'(200 + i), 1'b1, 1'b0);
            chk("stream_wused", 64'(wused), 64'd8);
        end
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("stream_last", rd_data, 64'(239));

        // Flush beats a concurrent write.
        for (int i = 0; i < 5; i++) step(1'b1, 64'(300 + i), 1'b0, 1'b0);
        step(1'b1, 64'hDEAD, 1'b0, 1'b1);
        chk("flush_wused", 64'(wused), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        step(1'b1, 64'h55, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("flush_after_data", rd_data, 64'h55);

        // Randomized traffic with shifting write/read bias and rare flushes.
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = ((i / 100) % 2 == 0) ? 75 : 30;
            step($urandom_range(0, 99) < wp,
                 {$urandom, $urandom},
                 $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 79) == 0);
        end

        // Async reset mid-burst at occupancy 7.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 64'(400 + i), 1'b0, 1'b0);
        chk("pre_rst_wused", 64'(wused), 64'd7);
        tx_we = 1'b1; tx_data = 64'h999;
        chk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        reset_checks("async_rst");
        model_reset();
        tx_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        step(1'b1, 64'h77, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("post_rst_data", rd_data, 64'h77);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
